// File: rtl/key_pkg.sv
// Shared definitions for the push-button conditioner: debounce state encoding and the
// default debounce window.
package key_pkg;

    localparam logic [1:0] KS_IDLE    = 2'd0;
    localparam logic [1:0] KS_FILT_DN = 2'd1;
    localparam logic [1:0] KS_DOWN    = 2'd2;
    localparam logic [1:0] KS_FILT_UP = 2'd3;

    // 20 ms at 50 MHz
    localparam int unsigned KEY_CNT_MAX_DEF = 1000000;

    typedef enum logic [1:0] {
        KsIdle   = KS_IDLE,
        KsFiltDn = KS_FILT_DN,
        KsDown   = KS_DOWN,
        KsFiltUp = KS_FILT_UP
    } key_state_e;

endpackage

// File: rtl/key_pulse_gen_if.sv
// Key pins in, press pulses and debounced levels out. The conditioner uses the slave
// modport; whoever drives the pins uses master.
interface key_pulse_gen_if;
    logic key_ps_n;
    logic key_rst_n;
    logic key_ps_en;
    logic key_rst_en;
    logic key_ps_level;
    logic key_rst_level;

    modport master (
        output key_ps_n, key_rst_n,
        input  key_ps_en, key_rst_en, key_ps_level, key_rst_level
    );

    modport slave (
        input  key_ps_n, key_rst_n,
        output key_ps_en, key_rst_en, key_ps_level, key_rst_level
    );
endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchroniser, debounce FSM with window counter, registered
// one-cycle press pulse and debounced level.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned CNT_MAX = KEY_CNT_MAX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_i,
    output logic en_o,
    output logic level_o
);

    localparam int unsigned CNT_W = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(CNT_MAX - 1);

    logic             sync1_q;
    logic             key_s_q;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;
    logic             level_q, level_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            key_s_q <= 1'b1;
            state_q <= KsIdle;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= key_n_i;
            key_s_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            level_q <= level_d;
        end
    end

    // Counter is cleared on every state change, so it never exceeds CntLast.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en_d    = 1'b0;
        unique case (state_q)
            KsIdle: begin
                if (!key_s_q) begin
                    state_d = KsFiltDn;
                    cnt_d   = '0;
                end
            end
            KsFiltDn: begin
                if (key_s_q) begin
                    state_d = KsIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = KsDown;
                    cnt_d   = '0;
                    en_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            KsDown: begin
                if (key_s_q) begin
                    state_d = KsFiltUp;
                    cnt_d   = '0;
                end
            end
            KsFiltUp: begin
                if (!key_s_q) begin
                    state_d = KsDown;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = KsIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = KsIdle;
                cnt_d   = '0;
            end
        endcase
        level_d = (state_d == KsDown) || (state_d == KsFiltUp);
    end

    assign en_o    = en_q;
    assign level_o = level_q;

endmodule

// File: rtl/key_pulse_gen.sv
// Stopwatch push-button front end: debounces pause/start and reset keys into press pulses.
// Define KEY_RST_PRIORITY_EN to suppress pause pulses while the reset key is held or firing.
module key_pulse_gen
    import key_pkg::*;
#(
    parameter int unsigned CNT_MAX = KEY_CNT_MAX_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    key_pulse_gen_if.slave  bus
);

    logic ps_en;
    logic ps_level;
    logic rst_en;
    logic rst_level;

    key_debounce_ch #(
        .CNT_MAX (CNT_MAX)
    ) u_ps_ch (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_n_i (bus.key_ps_n),
        .en_o    (ps_en),
        .level_o (ps_level)
    );

    key_debounce_ch #(
        .CNT_MAX (CNT_MAX)
    ) u_rst_ch (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_n_i (bus.key_rst_n),
        .en_o    (rst_en),
        .level_o (rst_level)
    );

`ifdef KEY_RST_PRIORITY_EN
    // rst_level is high exactly when the reset channel is in DOWN or FILT_UP.
    assign bus.key_ps_en = ps_en & ~(rst_level | rst_en);
`else
    assign bus.key_ps_en = ps_en;
`endif
    assign bus.key_rst_en    = rst_en;
    assign bus.key_ps_level  = ps_level;
    assign bus.key_rst_level = rst_level;

endmodule

// File: doc/key_pulse_gen.md
Name: key_pulse_gen

Overview:
- Front-end conditioner for the stopwatch's two push-buttons: pause/start and reset.
- Synchronises each raw active-low key pin and debounces it with a per-key state machine.
- Emits one-clock enable pulses, key_ps_en and key_rst_en, on each confirmed press. These drive the stopwatch counter stage's key inputs directly.
- Also exposes the debounced key levels for LEDs and debug.

Parameters:
- CNT_MAX, 1000000, debounce window in clk cycles (20 ms at 50 MHz); legal range ≥ 2.
- CNT_W, $clog2(CNT_MAX), width of each debounce counter; derived, not overridden.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset (sampled on clk rising edge only).
- key_ps_n  in  1  raw pause/start button, active-low, asynchronous to clk, bouncy.
- key_rst_n  in  1  raw reset button, active-low, asynchronous to clk, bouncy.
- key_ps_en  out  1  one-cycle pulse per confirmed pause/start press.
- key_rst_en  out  1  one-cycle pulse per confirmed reset press.
- key_ps_level  out  1  debounced pause/start state, 1 = held.
- key_rst_level  out  1  debounced reset state, 1 = held.

Behaviour:
- Reset: when rst_n is low at a clk edge:
  - both synchroniser flops go to 1 (released);
  - both channel FSMs go to IDLE and both counters to 0;
  - all four outputs go to 0.
- rst_n is synchronous: asserting it mid-filter discards the partial count, and no pulse is emitted.
- Synchroniser: two flops per key. The FSM uses only the second flop's value, key_s.
- Each channel runs an independent FSM, registered, with states IDLE, FILT_DN, DOWN, FILT_UP:
  - IDLE: if key_s=0, go to FILT_DN with cnt←0. Otherwise stay.
  - FILT_DN: if key_s=1, return to IDLE (bounce rejected) with cnt←0. Otherwise cnt←cnt+1. When cnt=CNT_MAX-1 on that edge, go to DOWN and assert en for exactly one cycle.
  - DOWN: level=1. If key_s=1, go to FILT_UP with cnt←0.
  - FILT_UP: if key_s=0, return to DOWN. Otherwise cnt++. When cnt=CNT_MAX-1, go to IDLE.
- level is 1 in DOWN and FILT_UP, 0 otherwise. It is registered.
- No pulse is ever generated on release.
- Latency: let e0 be the edge whose synchroniser-1 flop first captures a stable low. en is high for the single cycle after edge e0+CNT_MAX+2. level rises on the same edge.
- Holding a key indefinitely gives exactly one pulse; there is no auto-repeat.
- Counter: CNT_W bits, never wraps. It is cleared on every state change and bounded by CNT_MAX-1.
- Channels are independent. Both en pulses may assert in the same cycle, subject to the optional feature below.

Optional Feature:
- Macro: KEY_RST_PRIORITY_EN.
- Defined:
  - key_ps_en is forced to 0 in any cycle where the reset channel is in DOWN or FILT_UP, or key_rst_en is 1. A pause press during a held reset is swallowed, not deferred.
  - key_ps_level is unaffected.
- Undefined: channels are fully independent, and simultaneous pulses are passed through.

Decomposition:
- Shared package key_pkg holds:
  - the state encoding localparams KS_IDLE=2'd0, KS_FILT_DN=2'd1, KS_DOWN=2'd2, KS_FILT_UP=2'd3;
  - the default debounce constant KEY_CNT_MAX_DEF=1000000.
- Sub-module key_debounce_ch contains the synchroniser, FSM, counter, en and level for one key, parameterised by CNT_MAX.
- The top instantiates it twice and applies the priority gating under the macro.

Test Plan (CNT_MAX=4 for simulation):
- Reset: rst_n=0 for 3 cycles with both keys low → all outputs 0 and FSMs IDLE. After release with key_ps_n held low → key_ps_en pulses exactly once, 7 edges after first sampling (e0+6), width 1 cycle.
- Bounce reject: key_ps_n low for 3 cycles, high 1 cycle, low again stably → no pulse on first burst. Exactly one pulse counted from the second stable low.
- Hold and release: key_rst_n low for 50 cycles then high → one key_rst_en pulse. key_rst_level is 1 from the pulse cycle until 5 cycles after release settles, then 0. No pulse on release.
- Release bounce: while DOWN, key_ps_n toggles high for 2 cycles and back low → level stays 1 and no second pulse.
- Simultaneous press: both keys low on the same edge:
  - without KEY_RST_PRIORITY_EN, both en pulses occur in the same cycle;
  - with it, only key_rst_en pulses.
  - With the macro, a pause press while reset is held gives no key_ps_en.
- Mid-filter reset: rst_n asserted at cnt=2 in FILT_DN → no pulse. After rst_n release with the key still low, a full new window (e0+6) is required before the pulse.
